dsp_addsub_pipe: RTL



---
 rtl/dsp_addsub_pipe.sv | 115 +++++++++++
 1 files changed

// File: rtl/dsp_addsub_pipe.sv
// Lane-pipelined adder/subtractor: one 16-bit lane per stage, carry registered between stages.
// Optional macro DSP_ADDSUB_SAT_EN saturates out_result on signed overflow.
module dsp_addsub_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sub,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int LANES = WIDTH / 16;
    localparam int MSB   = WIDTH - 1;

    if ((WIDTH % 16) != 0 || WIDTH < 16 || WIDTH > 64) begin : g_bad_width
        $error("dsp_addsub_pipe: WIDTH=%0d must be a multiple of 16 in 16..64", WIDTH);
    end

    logic [LANES-1:0] v_q, c_q;
    logic [WIDTH-1:0] a_q [LANES];
    logic [WIDTH-1:0] b_q [LANES];
    logic [WIDTH-1:0] r_q [LANES];

    logic [LANES-1:0] v_d, c_d;
    logic [WIDTH-1:0] a_d [LANES];
    logic [WIDTH-1:0] b_d [LANES];
    logic [WIDTH-1:0] r_d [LANES];

    logic             adv;
    logic             cur_v, cur_c;
    logic [WIDTH-1:0] cur_a, cur_b, cur_r;
    logic [16:0]      lane_sum;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // B is inverted up front for subtraction; the +1 enters as the lane-0 carry-in.
    // Each stage's inputs are the previous stage's registers (or the ports for stage 0).
    always_comb begin
        cur_v    = in_valid;
        cur_c    = in_sub;
        cur_a    = in_a;
        cur_b    = in_sub ? ~in_b : in_b;
        cur_r    = '0;
        lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_sum = {1'b0, cur_a[16*k +: 16]} + {1'b0, cur_b[16*k +: 16]} + {16'd0, cur_c};
            v_d[k]   = cur_v;
            c_d[k]   = lane_sum[16];
            a_d[k]   = cur_a;
            b_d[k]   = cur_b;
            r_d[k]   = cur_r;
            r_d[k][16*k +: 16] = lane_sum[15:0];
            cur_v    = v_q[k];
            cur_c    = c_q[k];
            cur_a    = a_q[k];
            cur_b    = b_q[k];
            cur_r    = r_q[k];
        end
    end

    // The whole pipe moves together; a stall freezes every stage, bubbles included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < LANES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
            end
        end else if (adv) begin
            v_q <= v_d;
            c_q <= c_d;
            for (int k = 0; k < LANES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                r_q[k] <= r_d[k];
            end
        end
    end

    logic [WIDTH-1:0] last_a, last_b, last_r, final_r;
    logic             raw_ovf;

    assign last_a  = a_q[LANES-1];
    assign last_b  = b_q[LANES-1];
    assign last_r  = r_q[LANES-1];
    assign raw_ovf = (last_a[MSB] == last_b[MSB]) && (last_r[MSB] != last_a[MSB]);

`ifdef DSP_ADDSUB_SAT_EN
    // Overflow direction follows the sign of A: positive clamps to max, negative to min.
    assign final_r = !raw_ovf ? last_r :
                     (last_a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
`else
    assign final_r = last_r;
`endif

    // Outputs are qualified by the last-stage valid so idle/bubble cycles read as all zero.
    assign out_valid  = v_q[LANES-1];
    assign out_result = out_valid ? final_r : '0;
    assign out_carry  = out_valid & c_q[LANES-1];
    assign out_ovf    = out_valid & raw_ovf;
    assign out_zero   = out_valid & ~|final_r;

endmodule
